// File: rtl/flag_branch_unit.sv
// Flag register plus a branch resolver with a one-cycle result pipeline and a saturating taken counter.
// The optional macro FLAG_FWD_EN forwards same-cycle flag writes into branch evaluation instead of stalling.
module flag_branch_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [3:0]        alu_opcode,
    input  logic [2:0]        alu_flags,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              br_reg,
    input  logic [2:0]        br_cond,
    input  logic [8:0]        br_offset,
    input  logic [DATA_W-1:0] br_rs_data,
    input  logic [DATA_W-1:0] br_pc,
    output logic              res_valid,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_pc,
    output logic [2:0]        flags_q,
    output logic [DATA_W-1:0] taken_cnt
);

    // Flag bit order: [2]=N, [1]=Z, [0]=V
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (cond)
            3'b000:  cond_met = !z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = !z && !n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z || !n;
            3'b101:  cond_met = n || z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] cnt);
        sat_inc = (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic              wr_nzv, wr_z;
    logic [2:0]        flags_new, eval_flags;
    logic              ready_en;
    logic              accept_p0, taken_p0;
    logic signed [DATA_W-1:0] off_ext_p0;
    logic [DATA_W-1:0] seq_pc_p0, target_p0, next_pc_p0;

    always_comb begin
        wr_nzv    = alu_valid && (alu_opcode == 4'h0 || alu_opcode == 4'h1);
        wr_z      = alu_valid && (alu_opcode inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6});
        flags_new = flags_q;
        if (wr_nzv)
            flags_new = alu_flags;
        else if (wr_z)
            flags_new[1] = alu_flags[1];
    end

`ifdef FLAG_FWD_EN
    assign eval_flags = flags_new;
    assign br_ready   = ready_en;
`else
    // A flag-writing retire stalls the branch so it resolves against the committed flags next cycle
    assign eval_flags = flags_q;
    assign br_ready   = ready_en && !wr_z;
`endif

    always_comb begin
        accept_p0  = br_valid && br_ready;
        taken_p0   = cond_met(br_cond, eval_flags);
        off_ext_p0 = {{(DATA_W-10){br_offset[8]}}, br_offset, 1'b0};
        seq_pc_p0  = br_pc + DATA_W'(2);
        target_p0  = br_reg ? br_rs_data : seq_pc_p0 + off_ext_p0;
        next_pc_p0 = taken_p0 ? target_p0 : seq_pc_p0;
    end

    // p0 -> p1: registered branch result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            flags_q   <= 3'b000;
            res_valid <= 1'b0;
            res_taken <= 1'b0;
            res_pc    <= '0;
            taken_cnt <= '0;
        end else begin
            ready_en  <= 1'b1;
            flags_q   <= flags_new;
            res_valid <= accept_p0;
            if (accept_p0) begin
                res_taken <= taken_p0;
                res_pc    <= next_pc_p0;
                if (taken_p0)
                    taken_cnt <= sat_inc(taken_cnt);
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag updates, conditions, targets, hazard handling, saturation, reset.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_flags;
    logic        br_valid;
    logic        br_ready;
    logic        br_reg;
    logic [2:0]  br_cond;
    logic [8:0]  br_offset;
    logic [15:0] br_rs_data;
    logic [15:0] br_pc;
    logic        res_valid;
    logic        res_taken;
    logic [15:0] res_pc;
    logic [2:0]  flags_q;
    logic [15:0] taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    flag_branch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_opcode (alu_opcode),
        .alu_flags  (alu_flags),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_reg     (br_reg),
        .br_cond    (br_cond),
        .br_offset  (br_offset),
        .br_rs_data (br_rs_data),
        .br_pc      (br_pc),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_pc     (res_pc),
        .flags_q    (flags_q),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [2:0] fl);
        alu_valid  = 1'b1;
        alu_opcode = op;
        alu_flags  = fl;
        tick();
        alu_valid  = 1'b0;
    endtask

    task automatic branch(input string tag, input logic is_reg, input logic [2:0] cond,
                          input logic [8:0] off, input logic [15:0] rs, input logic [15:0] pc,
                          input logic exp_taken, input logic [15:0] exp_pc);
        br_valid   = 1'b1;
        br_reg     = is_reg;
        br_cond    = cond;
        br_offset  = off;
        br_rs_data = rs;
        br_pc      = pc;
        tick();
        br_valid = 1'b0;
        check_eq({tag, "_valid"}, res_valid, 1'b1);
        check_eq({tag, "_taken"}, res_taken, exp_taken);
        check_eq({tag, "_pc"}, res_pc, exp_pc);
        if (exp_taken && exp_cnt != 16'hFFFF) exp_cnt++;
    endtask

    initial begin
        int n, seen;
        rst_n = 1'b0; alu_valid = 1'b0; alu_opcode = '0; alu_flags = '0;
        br_valid = 1'b0; br_reg = 1'b0; br_cond = '0; br_offset = '0;
        br_rs_data = '0; br_pc = '0;

        tick(); tick();
        check_eq("rst_flags", flags_q, 3'b000);
        check_eq("rst_valid", res_valid, 1'b0);
        check_eq("rst_pc", res_pc, 16'h0000);
        check_eq("rst_cnt", taken_cnt, 16'h0000);
        check_eq("rst_ready", br_ready, 1'b0);

        #2 rst_n = 1'b1;
        #1 check_eq("ready_before_edge", br_ready, 1'b0);
        tick();
        check_eq("ready_after_edge", br_ready, 1'b1);

        // SUB writes N,Z,V; hazard stall visible while it retires
        alu_valid = 1'b1; alu_opcode = 4'h1; alu_flags = 3'b010;
        #1;
`ifdef FLAG_FWD_EN
        check_eq("ready_fwd_sub", br_ready, 1'b1);
`else
        check_eq("ready_stall_sub", br_ready, 1'b0);
`endif
        tick();
        alu_valid = 1'b0;
        check_eq("flags_sub", flags_q, 3'b010);

        branch("b_eq", 1'b0, 3'b001, 9'h004, 16'h0, 16'h0100, 1'b1, 16'h010A);
        tick();
        check_eq("valid_pulse", res_valid, 1'b0);
        check_eq("cnt_one", taken_cnt, 16'd1);

        // Opcodes that leave flags alone, then XOR (Z only)
        alu_op(4'h2, 3'b101);
        alu_op(4'h7, 3'b101);
        alu_op(4'hC, 3'b101);
        check_eq("flags_nowrite", flags_q, 3'b010);
        alu_op(4'h3, 3'b101);
        check_eq("flags_xor", flags_q, 3'b000);

        branch("b_wrap", 1'b0, 3'b111, 9'h000, 16'h0, 16'hFFFE, 1'b1, 16'h0000);
        branch("b_neg", 1'b0, 3'b111, 9'h1FF, 16'h0, 16'h0000, 1'b1, 16'h0000);
        branch("b_back", 1'b0, 3'b111, 9'h1F0, 16'h0, 16'h0100, 1'b1, 16'h00E2);
        branch("br_ov0", 1'b1, 3'b110, 9'h000, 16'h1234, 16'h0040, 1'b0, 16'h0042);
        alu_op(4'h0, 3'b001);
        check_eq("flags_add", flags_q, 3'b001);
        branch("br_ov1", 1'b1, 3'b110, 9'h000, 16'h1234, 16'h0040, 1'b1, 16'h1234);
        // N=0 Z=0 V=1, back-to-back resolves
        branch("c_ne", 1'b0, 3'b000, 9'h010, 16'h0, 16'h0200, 1'b1, 16'h0222);
        branch("c_gt", 1'b0, 3'b010, 9'h010, 16'h0, 16'h0200, 1'b1, 16'h0222);
        branch("c_lt", 1'b0, 3'b011, 9'h010, 16'h0, 16'h0200, 1'b0, 16'h0202);
        branch("c_le", 1'b0, 3'b101, 9'h010, 16'h0, 16'h0200, 1'b0, 16'h0202);
        alu_op(4'h1, 3'b100);
        branch("c_lt_n", 1'b0, 3'b011, 9'h002, 16'h0, 16'h0300, 1'b1, 16'h0306);
        branch("c_ge_n", 1'b0, 3'b100, 9'h002, 16'h0, 16'h0300, 1'b0, 16'h0302);
        tick();
        check_eq("cnt_mid", taken_cnt, exp_cnt);

        // Flag write and EQ branch offered together; flags were N=1 Z=0 V=0
        alu_valid = 1'b1; alu_opcode = 4'h0; alu_flags = 3'b010;
        br_valid = 1'b1; br_reg = 1'b0; br_cond = 3'b001; br_offset = 9'h000; br_pc = 16'h0500;
        #1;
`ifdef FLAG_FWD_EN
        check_eq("haz_ready", br_ready, 1'b1);
        tick();
        alu_valid = 1'b0; br_valid = 1'b0;
`else
        check_eq("haz_ready", br_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        check_eq("haz_no_res", res_valid, 1'b0);
        #1 check_eq("haz_ready_next", br_ready, 1'b1);
        tick();
        br_valid = 1'b0;
`endif
        check_eq("haz_valid", res_valid, 1'b1);
        check_eq("haz_taken", res_taken, 1'b1);
        check_eq("haz_pc", res_pc, 16'h0502);
        exp_cnt++;

        // Drive the counter to saturation with always-taken branches
        n = 65535 - exp_cnt;
        br_valid = 1'b1; br_cond = 3'b111;
        repeat (n) tick();
        br_valid = 1'b0;
        exp_cnt = 65535;
        tick();
        check_eq("cnt_full", taken_cnt, 16'hFFFF);
        branch("b_sat", 1'b0, 3'b111, 9'h000, 16'h0, 16'h0010, 1'b1, 16'h0012);
        tick();
        check_eq("cnt_sat", taken_cnt, 16'hFFFF);

        // Reset lands while a branch is being accepted
        br_valid = 1'b1; br_cond = 3'b111; br_pc = 16'h0700;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", res_valid, 1'b0);
        check_eq("mid_rst_pc", res_pc, 16'h0000);
        check_eq("mid_rst_taken", res_taken, 1'b0);
        check_eq("mid_rst_cnt", taken_cnt, 16'h0000);
        check_eq("mid_rst_flags", flags_q, 3'b000);
        check_eq("mid_rst_ready", br_ready, 1'b0);
        br_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            tick();
            if (res_valid) seen++;
        end
        check_eq("post_rst_no_res", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
